// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath blocks: default widths and the
// operand-feeder state encoding.
package tpu_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ACC_W      = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/mmu_feeder.sv
// Sequences one 2x2 matrix multiply into the weight-stationary systolic array:
// weight load, skewed activation feed, drain, then a done pulse.
module mmu_feeder
  import tpu_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEF,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  // start is a single-cycle request; it is sampled only in IDLE, where the
  // operands on a00..w11 are captured in the same cycle. No back-pressure.
  input  logic              start,
  input  logic [DATA_W-1:0] a00,
  input  logic [DATA_W-1:0] a01,
  input  logic [DATA_W-1:0] a10,
  input  logic [DATA_W-1:0] a11,
  input  logic [DATA_W-1:0] w00,
  input  logic [DATA_W-1:0] w01,
  input  logic [DATA_W-1:0] w10,
  input  logic [DATA_W-1:0] w11,
  output logic              load_weight,
  output logic              valid,
  output logic [DATA_W-1:0] a_in1,
  output logic [DATA_W-1:0] a_in2,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] weight4,
  output logic              busy,
  output logic              done,
  output feeder_state_e     dbg_state
);

  localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'((DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0);

  feeder_state_e     state_q;
  logic [1:0]        f_q;
  logic [DCW-1:0]    drain_q;
  logic [DATA_W-1:0] a00_q, a01_q, a10_q, a11_q;
  logic [DATA_W-1:0] wgt1_q, wgt2_q, wgt3_q, wgt4_q;
  logic              load_q, valid_q, busy_q, done_q;
  logic [DATA_W-1:0] a1_q, a2_q;

  // Outputs are computed for the state being entered, so every output is a
  // flop that lines up with the state it belongs to.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      f_q     <= '0;
      drain_q <= '0;
      a00_q   <= '0;
      a01_q   <= '0;
      a10_q   <= '0;
      a11_q   <= '0;
      wgt1_q  <= '0;
      wgt2_q  <= '0;
      wgt3_q  <= '0;
      wgt4_q  <= '0;
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
    end else begin
      load_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      a1_q    <= '0;
      a2_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a00_q   <= a00;
            a01_q   <= a01;
            a10_q   <= a10;
            a11_q   <= a11;
            wgt1_q  <= w00;
            wgt2_q  <= w01;
            wgt3_q  <= w10;
            wgt4_q  <= w11;
            load_q  <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          state_q <= ST_FEED;
          f_q     <= '0;
          valid_q <= 1'b1;
          a1_q    <= a00_q;
        end
        ST_FEED: begin
          if (f_q == 2'd2) begin
            if (DRAIN_CYCLES == 0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
              drain_q <= '0;
              valid_q <= 1'b1;
            end
          end else begin
            // Row 1 trails row 0 by one cycle to meet the partial sum hop.
            f_q     <= f_q + 2'd1;
            valid_q <= 1'b1;
            if (f_q == 2'd0) begin
              a1_q <= a10_q;
              a2_q <= a01_q;
            end else begin
              a2_q <= a11_q;
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == DRAIN_LAST) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            drain_q <= drain_q + 1'b1;
            valid_q <= 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign load_weight = load_q;
  assign valid       = valid_q;
  assign a_in1       = a1_q;
  assign a_in2       = a2_q;
  assign weight1     = wgt1_q;
  assign weight2     = wgt2_q;
  assign weight3     = wgt3_q;
  assign weight4     = wgt4_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign dbg_state   = state_q;

endmodule
